// File: rtl/int_ctrl_multi.sv
// Multi-source interrupt controller on the m_int store bus: per-source periodic
// timers and rising-edge inputs, combined through a mask into one interrupt line.
module int_ctrl_multi #(
    parameter int          NUM_SRC  = 4,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] INT_BASE = 32'h0000_7f20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        m_int_addr,
    input  logic [3:0]         m_int_byteen,
    input  logic [31:0]        m_int_wdata,
    output logic [31:0]        m_int_rdata,
    input  logic [NUM_SRC-1:0] ext_irq,
    output logic               interrupt,
    output logic [NUM_SRC-1:0] pending
);

    localparam logic [29:0] BASE_WORD = INT_BASE[31:2];

    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] ext_prev;
    logic [CNT_W-1:0]   period [NUM_SRC];
    logic [CNT_W-1:0]   cnt    [NUM_SRC];

    logic [29:0]        word_off;
    logic               sel_ack;
    logic               sel_mask;
    logic [NUM_SRC-1:0] sel_period;
    logic               any_store;
    logic               full_store;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] set_t;
    logic [NUM_SRC-1:0] set_e;
    logic [NUM_SRC-1:0] pending_next;
    logic [NUM_SRC-1:0] mask_next;
    logic               unused_bits;

    // Address bits [1:0] and the wdata bits above each register width are don't-care.
    assign unused_bits = ^{m_int_addr[1:0], m_int_wdata};

    assign word_off   = m_int_addr[31:2] - BASE_WORD;
    assign sel_ack    = (word_off == 30'd0);
    assign sel_mask   = (word_off == 30'd1);
    assign any_store  = |m_int_byteen;
    assign full_store = (m_int_byteen == 4'hF);

    always_comb begin
        sel_period = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            sel_period[i] = (word_off == 30'(i + 2));
        end
    end

    always_comb begin
        set_t = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            set_t[i] = (period[i] != '0) && (cnt[i] == period[i] - CNT_W'(1));
        end
    end

    assign set_e = ext_irq & ~ext_prev;
    assign clr   = (sel_ack && any_store) ? m_int_wdata[NUM_SRC-1:0] : '0;

    // Sets win over a same-cycle ACK so an event landing on the ACK cycle is kept.
    assign pending_next = (pending & ~clr) | set_t | set_e;
    assign mask_next    = (sel_mask && full_store) ? m_int_wdata[NUM_SRC-1:0] : mask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            mask      <= '0;
            ext_prev  <= '0;
            interrupt <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            pending   <= pending_next;
            mask      <= mask_next;
            ext_prev  <= ext_irq;
            interrupt <= |(pending_next & mask_next);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (full_store && sel_period[i]) begin
                    period[i] <= m_int_wdata[CNT_W-1:0];
                    cnt[i]    <= '0;
                end else if ((period[i] == '0) || set_t[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        m_int_rdata = '0;
        if (sel_ack) begin
            m_int_rdata = 32'(pending);
        end else if (sel_mask) begin
            m_int_rdata = 32'(mask);
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (sel_period[i]) begin
                    m_int_rdata = 32'(period[i]);
                end
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl_multi.sv
// Bench for int_ctrl_multi: a driver feeds a reference model and a scoreboard queue,
// a negedge monitor compares the DUT against the queued expectations.
module tb_int_ctrl_multi;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h0000_7f20;

    logic          clk;
    logic          reset;
    logic [31:0]   addr;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [N-1:0]  ext;
    logic          irq;
    logic [N-1:0]  pend;

    int_ctrl_multi #(.NUM_SRC(N), .CNT_W(16), .INT_BASE(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .m_int_addr   (addr),
        .m_int_byteen (be),
        .m_int_wdata  (wdata),
        .m_int_rdata  (rdata),
        .ext_irq      (ext),
        .interrupt    (irq),
        .pending      (pend)
    );

    typedef struct {
        logic         irq;
        logic [N-1:0] pend;
        logic [31:0]  rdata;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model: timer i fires on cycle c when (c - base) mod period == period-1,
    // where base is the first cycle after the PERIOD write.
    logic [N-1:0] m_pend, m_mask, m_prev;
    logic         m_irq;
    int unsigned  m_per  [N];
    longint       m_base [N];
    longint       cyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned off;
        off = (a >> 2) - (BASE >> 2);
        if (off == 0) return 32'(m_pend);
        if (off == 1) return 32'(m_mask);
        if (off >= 2 && off < 2 + N) return m_per[off - 2];
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_pend = '0;
        m_mask = '0;
        m_prev = '0;
        m_irq  = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_per[i]  = 0;
            m_base[i] = 0;
        end
    endtask

    // Called at posedge+1: drive one bus cycle, queue expected outputs, advance the model.
    task automatic cycle(input logic [31:0] a, input logic [3:0] b, input logic [31:0] w);
        exp_t         e;
        logic [N-1:0] st, se, clr, nm;
        int unsigned  off;
        addr  = a;
        be    = b;
        wdata = w;
        e.irq   = m_irq;
        e.pend  = m_pend;
        e.rdata = m_read(a);
        sbq.push_back(e);
        off = (a >> 2) - (BASE >> 2);
        for (int i = 0; i < N; i++) begin
            st[i] = (m_per[i] != 0) &&
                    (((cyc - m_base[i]) % longint'(m_per[i])) == longint'(m_per[i]) - 1);
        end
        se  = ext & ~m_prev;
        clr = (off == 0 && b != 4'h0) ? w[N-1:0] : '0;
        nm  = (off == 1 && b == 4'hF) ? w[N-1:0] : m_mask;
        if (off >= 2 && off < 2 + N && b == 4'hF) begin
            m_per[off - 2]  = w & 32'h0000_FFFF;
            m_base[off - 2] = cyc + 1;
        end
        m_pend = (m_pend & ~clr) | st | se;
        m_mask = nm;
        m_prev = ext;
        m_irq  = |(m_pend & m_mask);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cycle();
        exp_t e;
        addr  = $urandom;
        be    = 4'($urandom);
        wdata = $urandom;
        ext   = N'($urandom);
        e.irq   = 1'b0;
        e.pend  = '0;
        e.rdata = m_read(addr);
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int unsigned off, input logic [31:0] d);
        cycle(BASE + off, 4'hF, d);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(BASE + 4 * $urandom_range(0, 5), 4'h0, $urandom);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("interrupt", 32'(irq), 32'(e.irq));
                check("pending", 32'(pend), 32'(e.pend));
                check("rdata", rdata, e.rdata);
            end
        end
    end

    initial begin
        logic [31:0] d;
        logic [3:0]  b;
        int          r;
        reset = 1'b0;
        addr  = '0;
        be    = '0;
        wdata = '0;
        ext   = '0;
        model_reset();
        @(posedge clk);
        #1;

        // reset with random bus traffic, then release and read back zeros
        repeat (5) rst_cycle();
        ext   = '0;
        reset = 1'b1;
        cycle(BASE, 4'h0, 0);
        cycle(BASE + 4, 4'h0, 0);
        cycle(BASE + 8, 4'h0, 0);

        // periodic timer 0, period 5
        wr(4, 32'h1);
        wr(8, 32'd5);
        idle(4);
        check("timer_not_yet", 32'(pend[0]), 32'h0);
        idle(1);
        check("timer_first_fire", 32'(pend[0]), 32'h1);
        check("timer_irq_rise", 32'(irq), 32'h1);
        idle(2);
        wr(0, 32'h1);
        check("ack_drops_irq", 32'(irq), 32'h0);
        idle(12);
        wr(8, 32'd0);
        wr(0, 32'hF);

        // masking with timer 1, period 3
        wr(4, 32'h0);
        wr(12, 32'd3);
        idle(4);
        check("masked_pending", 32'(pend), 32'h2);
        check("masked_irq", 32'(irq), 32'h0);
        wr(4, 32'h2);
        check("unmask_irq", 32'(irq), 32'h1);
        cycle(BASE + 4, 4'b0011, 32'h0);
        check("partial_mask_ignored", rdata, 32'h2);
        cycle(BASE + 4, 4'h0, 0);
        wr(12, 32'd0);
        wr(0, 32'hF);

        // external edge on source 2
        wr(4, 32'h4);
        ext[2] = 1'b1;
        idle(3);
        check("ext_set", 32'(pend[2]), 32'h1);
        wr(0, 32'h4);
        idle(6);
        check("ext_level_no_reset", 32'(pend[2]), 32'h0);
        ext[2] = 1'b0;
        idle(2);
        check("ext_fall_no_set", 32'(pend[2]), 32'h0);
        ext[2] = 1'b1;
        idle(1);
        check("ext_second_edge", 32'(pend[2]), 32'h1);
        check("ext_irq", 32'(irq), 32'h1);
        wr(0, 32'h4);

        // set beats clear on timer 0, period 4
        wr(4, 32'h1);
        wr(8, 32'd4);
        idle(7);
        check("sbc_pre", 32'(pend[0]), 32'h1);
        wr(0, 32'h1);
        check("sbc_pending", 32'(pend[0]), 32'h1);
        check("sbc_irq", 32'(irq), 32'h1);
        idle(2);
        wr(8, 32'd0);
        wr(0, 32'hF);

        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 5) == 0) ext = ext ^ N'($urandom);
            r = $urandom_range(0, 9);
            case ($urandom_range(0, 5))
                0: b = 4'h0;
                1: b = 4'b0011;
                2: b = 4'b0001;
                default: b = 4'hF;
            endcase
            d = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0) d = d | ($urandom & 32'hFFFF_0000);
            if (r <= 2)      cycle(BASE + 32'($urandom_range(0, 3)), b, $urandom);
            else if (r == 3) cycle(BASE + 4, b, $urandom);
            else if (r <= 5) cycle(BASE + 8 + 4 * $urandom_range(0, N), b, d);
            else if (r == 6) cycle($urandom, b, $urandom);
            else if (r == 7) cycle(BASE - 4, b, $urandom);
            else             idle(1);
        end

        // asynchronous reset mid-count
        ext = '0;
        wr(4, 32'hF);
        for (int i = 0; i < N; i++) wr(8 + 4 * i, 32'd1);
        idle(2);
        check("async_pre_pending", 32'(pend), 32'hF);
        check("async_pre_irq", 32'(irq), 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("async_irq", 32'(irq), 32'h0);
        check("async_pending", 32'(pend), 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr(4, 32'h1);
        wr(8, 32'd3);
        idle(10);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
